// File: rtl/tuser_in_arb.sv
// tuser_in_arb: 2:1 packet-granular round-robin arbiter in front of tuser_in_fsm.
// A grant is held from the first beat through the tlast beat, so tuser stays
// unbroken per packet. The datapath is a pure combinational mux; the only state
// is the grant FSM and the last-granted pointer.
// Optional feature macro: TARB_PKT_CNT_EN enables per-requester completed-packet
// counters on cnt0/cnt1; without it both outputs are tied to zero.
//
// Handshake: a beat moves on any cycle where valid and ready are both high at
// the rising edge. Only the granted requester ever sees ready, and its ready is
// m_ready passed straight through; m_valid never depends on m_ready.
module tuser_in_arb #(
    parameter int DATA_W  = 256,
    parameter int KEEP_W  = 32,
    parameter int TUSER_W = 128
) (
    input  logic               tarb_aclk,
    input  logic               tarb_arst,
    input  logic               s0_valid,
    output logic               s0_ready,
    input  logic [DATA_W-1:0]  s0_data,
    input  logic [KEEP_W-1:0]  s0_keep,
    input  logic               s0_last,
    input  logic [TUSER_W-1:0] s0_user,
    input  logic               s1_valid,
    output logic               s1_ready,
    input  logic [DATA_W-1:0]  s1_data,
    input  logic [KEEP_W-1:0]  s1_keep,
    input  logic               s1_last,
    input  logic [TUSER_W-1:0] s1_user,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DATA_W-1:0]  m_data,
    output logic [KEEP_W-1:0]  m_keep,
    output logic               m_last,
    output logic [TUSER_W-1:0] m_user,
    output logic [0:2]         dbg_state,
    output logic [31:0]        cnt0,
    output logic [31:0]        cnt1
);

    localparam logic [2:0] IDLE = 3'b001;
    localparam logic [2:0] GNT0 = 3'b010;
    localparam logic [2:0] GNT1 = 3'b100;

    logic [2:0] state_q, state_d;
    // 1 means port 1 was granted last, so port 0 wins the next tie
    logic       last_gnt_q, last_gnt_d;
    logic       s0_done, s1_done;

    // tlast beat accepted from the granted port: packet complete
    assign s0_done = (state_q == GNT0) && s0_valid && m_ready && s0_last;
    assign s1_done = (state_q == GNT1) && s1_valid && m_ready && s1_last;

    assign dbg_state = state_q;

    // Next-state logic: arbitrate in IDLE, hold the grant until the tlast beat
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (s0_valid && (!s1_valid || last_gnt_q)) begin
                    state_d    = GNT0;
                    last_gnt_d = 1'b0;
                end else if (s1_valid) begin
                    state_d    = GNT1;
                    last_gnt_d = 1'b1;
                end
            end
            GNT0: begin
                if (s0_done) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (s1_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and priority pointer registers; reset hands the first tie to port 0
    always_ff @(posedge tarb_aclk) begin
        if (tarb_arst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Output mux: granted port passes through, everything else reads zero
    always_comb begin
        m_valid  = 1'b0;
        m_data   = '0;
        m_keep   = '0;
        m_last   = 1'b0;
        m_user   = '0;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        case (state_q)
            GNT0: begin
                m_valid  = s0_valid;
                m_data   = s0_data;
                m_keep   = s0_keep;
                m_last   = s0_last;
                m_user   = s0_user;
                s0_ready = m_ready;
            end
            GNT1: begin
                m_valid  = s1_valid;
                m_data   = s1_data;
                m_keep   = s1_keep;
                m_last   = s1_last;
                m_user   = s1_user;
                s1_ready = m_ready;
            end
            default: begin
            end
        endcase
    end

`ifdef TARB_PKT_CNT_EN
    logic [31:0] cnt0_q, cnt1_q;

    // Completed-packet counters, wrapping at 2^32
    always_ff @(posedge tarb_aclk) begin
        if (tarb_arst) begin
            cnt0_q <= 32'd0;
            cnt1_q <= 32'd0;
        end else begin
            if (s0_done) begin
                cnt0_q <= cnt0_q + 32'd1;
            end
            if (s1_done) begin
                cnt1_q <= cnt1_q + 32'd1;
            end
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = 32'd0;
    assign cnt1 = 32'd0;
`endif

endmodule
